cache_state_array: RTL and testbench
====================================

Name: cache_state_array

Overview:
- Per-line valid and dirty state for a set-associative cache, with SETS sets and WAYS ways.
- Sits beside the tag and data RAMs in the cache controller.
- Supports single-line valid/dirty updates and a registered per-set read of all ways.
- A built-in flush sequencer walks every line, hands each dirty line to the writeback path with a valid/ready handshake, and invalidates every line.

Parameters:
- INDEX_W, 3, set index width; SETS = 2**INDEX_W (localparam).
- WAYS, 2, associativity; power of two, at least 1.
- WAY_W, max(1, clog2(WAYS)), way select width (localparam, not overridable).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_index  in  INDEX_W  set to read.
- rd_valid  out  WAYS  valid bits of set rd_index; bit w is way w; registered.
- rd_dirty  out  WAYS  dirty bits of set rd_index; registered.
- wr_en  in  1  single-line update strobe.
- wr_index  in  INDEX_W  set to update.
- wr_way  in  WAY_W  way to update.
- wr_valid  in  1  new valid bit.
- wr_dirty  in  1  new dirty bit; stored as wr_dirty AND wr_valid.
- flush_req  in  1  start the flush walk; sampled only in IDLE.
- busy  out  1  high from the cycle after flush_req is accepted until done.
- wb_valid  out  1  a dirty line is presented for writeback.
- wb_index  out  INDEX_W  set of the presented line.
- wb_way  out  WAY_W  way of the presented line.
- wb_ready  in  1  writeback path accepts the presented line.
- done  out  1  one-cycle pulse when the flush completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - All valid and dirty bits are cleared.
  - rd_valid, rd_dirty, wb_valid, wb_index, wb_way, busy and done go to 0.
  - FSM returns to IDLE; the line counter returns to 0.
  - Reset during a flush aborts it immediately, and wb_valid drops without a handshake.
- Read:
  - One-cycle latency: at edge N, rd_valid and rd_dirty capture the contents of rd_index as it was before the edge N write.
  - A same-cycle write to the same set returns the old value; the new value is visible on the next read.
  - Reads operate in every FSM state.
- Write (wr_en=1, FSM in IDLE): line (wr_index, wr_way) takes valid=wr_valid and dirty=wr_valid AND wr_dirty.
- Write while busy: dropped silently, with no side effect.
- FSM states: IDLE, SCAN, WB_WAIT. Line counter {set, way} is INDEX_W+WAY_W bits; way is the least significant part.
- IDLE:
  - flush_req=1 leads to SCAN with the counter at 0.
  - If wr_en and flush_req are both high in the same cycle, the write is performed first and then the flush starts.
- SCAN, one line per cycle:
  - Line invalid or clean: clear valid and dirty, increment the counter.
  - Line valid and dirty: go to WB_WAIT; wb_valid=1 and wb_index/wb_way = counter, all registered outputs.
- WB_WAIT:
  - wb_valid, wb_index and wb_way stay stable until wb_ready=1.
  - On the wb_valid AND wb_ready edge: clear the line, drop wb_valid, increment the counter, return to SCAN.
  - wb_ready while wb_valid=0 is ignored.
- Completion: when the counter processes line SETS*WAYS-1 (it wraps to 0), the FSM enters IDLE, done=1 for one cycle, and busy falls in the same cycle done rises.
- flush_req while busy is ignored and is not queued.
- Flush latency with no dirty lines is exactly SETS*WAYS cycles of busy.
- WAYS=1: wr_way and wb_way are 1 bit wide; wr_way is ignored and wb_way is always 0.

Decomposition:
- Shared cache package holds:
  - the FSM state enum (IDLE/SCAN/WB_WAIT);
  - the default INDEX_W and WAYS values;
  - the WAY_W derivation function.
- One sub-module is natural: cache_state_bank, a WAYS-wide two-bit-per-line storage array with a registered read port and a write port.
- The flush FSM and counter stay in the top level.

Test Plan:
- Reset mid-operation: write set 3 way 1 valid+dirty, then pulse reset=0 -> rd_valid=0 and rd_dirty=0 for every set; busy=0; wb_valid=0.
- Write/read:
  - Write (idx 5, way 0, v=1, d=1) -> next-cycle read of idx 5 gives rd_valid=2'b01, rd_dirty=2'b01.
  - Write v=0, d=1 -> rd_dirty=2'b00.
- Read-during-write: read idx 2 in the same cycle as writing idx 2 way 1 valid -> rd_valid=2'b00; next cycle rd_valid=2'b10.
- Clean flush: all 16 lines valid and clean, pulse flush_req -> busy high for exactly 16 cycles, no wb_valid, one done pulse, all rd_valid=0 afterwards.
- Dirty flush with backpressure: lines (1,1) and (6,0) dirty, wb_ready held low for 5 cycles on each -> wb_valid held with stable wb_index/wb_way of 1/1 then 6/0; each line is cleared only after its handshake; done fires once.
- Flush abort and ignored inputs:
  - wr_en during busy leaves the array unchanged.
  - A second flush_req during busy is ignored.
  - reset asserted in WB_WAIT -> FSM is IDLE and wb_valid=0 immediately (asynchronously).

Source files
------------

// File: rtl/cache_state_array_pkg.sv
// Shared types and defaults for the cache line state array and its flush sequencer.
package cache_state_array_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    WB_WAIT = 2'd2
  } state_e;

  localparam int unsigned DEF_INDEX_W = 3;
  localparam int unsigned DEF_WAYS    = 2;

  // Way select width; a direct-mapped cache still carries a 1-bit way field.
  function automatic int unsigned way_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_state_bank.sv
// Valid/dirty storage for SETS x WAYS lines: registered per-set read, single-line write,
// and a combinational single-line peek used by the flush walker.
module cache_state_bank
  import cache_state_array_pkg::*;
#(
  parameter  int unsigned INDEX_W = DEF_INDEX_W,
  parameter  int unsigned WAYS    = DEF_WAYS,
  localparam int unsigned WAY_W   = way_width(WAYS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [WAYS-1:0]    rd_valid,
  output logic [WAYS-1:0]    rd_dirty,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WAY_W-1:0]   wr_way,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic [INDEX_W-1:0] pk_index,
  input  logic [WAY_W-1:0]   pk_way,
  output logic               pk_valid_c,
  output logic               pk_dirty_c
);

  localparam int unsigned SETS = 1 << INDEX_W;

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-1:0] wr_mask_c;
  logic [WAYS-1:0] pk_mask_c;
  logic            wr_dirty_c;

  // One-hot way masks; with a single way the way field is ignored.
  always_comb begin
    wr_mask_c = '0;
    pk_mask_c = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      wr_mask_c[w] = (WAYS == 1) || (WAY_W'(w) == wr_way);
      pk_mask_c[w] = (WAYS == 1) || (WAY_W'(w) == pk_way);
    end
  end

  assign wr_dirty_c = wr_dirty & wr_valid;
  assign pk_valid_c = |(valid_q[pk_index] & pk_mask_c);
  assign pk_dirty_c = |(dirty_q[pk_index] & pk_mask_c);

  // Read samples pre-write contents, so a same-cycle write to the read set returns old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      rd_valid <= '0;
      rd_dirty <= '0;
    end else begin
      rd_valid <= valid_q[rd_index];
      rd_dirty <= dirty_q[rd_index];
      if (wr_en) begin
        valid_q[wr_index] <= (valid_q[wr_index] & ~wr_mask_c) | ({WAYS{wr_valid}} & wr_mask_c);
        dirty_q[wr_index] <= (dirty_q[wr_index] & ~wr_mask_c) | ({WAYS{wr_dirty_c}} & wr_mask_c);
      end
    end
  end

endmodule

// File: rtl/cache_state_array.sv
// Cache valid/dirty state array with a flush sequencer that writes back dirty lines
// over a valid/ready handshake and invalidates every line.
module cache_state_array
  import cache_state_array_pkg::*;
#(
  parameter  int unsigned INDEX_W = DEF_INDEX_W,
  parameter  int unsigned WAYS    = DEF_WAYS,
  localparam int unsigned WAY_W   = way_width(WAYS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [WAYS-1:0]    rd_valid,
  output logic [WAYS-1:0]    rd_dirty,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WAY_W-1:0]   wr_way,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic               flush_req,
  output logic               busy,
  output logic               wb_valid,
  output logic [INDEX_W-1:0] wb_index,
  output logic [WAY_W-1:0]   wb_way,
  input  logic               wb_ready,
  output logic               done
);

  localparam int unsigned SETS      = 1 << INDEX_W;
  localparam int unsigned LINE_W    = INDEX_W + WAY_W;
  // A direct-mapped cache keeps the way bit at 0 by stepping over it.
  localparam int unsigned LINE_STEP = (WAYS == 1) ? 2 : 1;
  localparam int unsigned LAST_LINE = (SETS * WAYS - 1) * LINE_STEP;

  state_e             state;
  logic [LINE_W-1:0]  cnt;
  logic [INDEX_W-1:0] cnt_index;
  logic [WAY_W-1:0]   cnt_way;
  logic               line_valid_c;
  logic               line_dirty_c;
  logic               hit_c;
  logic               advance_c;
  logic               last_c;
  logic               bk_wr_en_c;
  logic [INDEX_W-1:0] bk_wr_index_c;
  logic [WAY_W-1:0]   bk_wr_way_c;
  logic               bk_wr_valid_c;
  logic               bk_wr_dirty_c;

  assign cnt_index = cnt[LINE_W-1:WAY_W];
  assign cnt_way   = cnt[WAY_W-1:0];
  assign hit_c     = line_valid_c & line_dirty_c;
  assign last_c    = (cnt == LINE_W'(LAST_LINE));
  assign advance_c = ((state == SCAN) && !hit_c) || ((state == WB_WAIT) && wb_valid && wb_ready);

  // Single bank write port: user writes in IDLE, line clears while walking.
  always_comb begin
    bk_wr_en_c    = 1'b0;
    bk_wr_index_c = wr_index;
    bk_wr_way_c   = wr_way;
    bk_wr_valid_c = wr_valid;
    bk_wr_dirty_c = wr_dirty;
    case (state)
      IDLE: bk_wr_en_c = wr_en;
      SCAN, WB_WAIT: begin
        bk_wr_en_c    = advance_c;
        bk_wr_index_c = cnt_index;
        bk_wr_way_c   = cnt_way;
        bk_wr_valid_c = 1'b0;
        bk_wr_dirty_c = 1'b0;
      end
      default: bk_wr_en_c = 1'b0;
    endcase
  end

  cache_state_bank #(
    .INDEX_W (INDEX_W),
    .WAYS    (WAYS)
  ) u_bank (
    .clk        (clk),
    .reset      (reset),
    .rd_index   (rd_index),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .wr_en      (bk_wr_en_c),
    .wr_index   (bk_wr_index_c),
    .wr_way     (bk_wr_way_c),
    .wr_valid   (bk_wr_valid_c),
    .wr_dirty   (bk_wr_dirty_c),
    .pk_index   (cnt_index),
    .pk_way     (cnt_way),
    .pk_valid_c (line_valid_c),
    .pk_dirty_c (line_dirty_c)
  );

  // Flush walker: state, line counter and all handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wb_valid <= 1'b0;
      wb_index <= '0;
      wb_way   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= SCAN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (hit_c) begin
            state    <= WB_WAIT;
            wb_valid <= 1'b1;
            wb_index <= cnt_index;
            wb_way   <= cnt_way;
          end
        end
        WB_WAIT: begin
          if (wb_ready) begin
            state    <= SCAN;
            wb_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (advance_c) begin
        cnt <= cnt + LINE_W'(LINE_STEP);
        if (last_c) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_state_array.sv
// Scoreboard bench for cache_state_array: reads and writebacks checked by a separate monitor.
module tb_cache_state_array;

  localparam int unsigned INDEX_W = 3;
  localparam int unsigned WAYS    = 2;
  localparam int unsigned WAY_W   = 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [INDEX_W-1:0] rd_index = '0;
  logic [WAYS-1:0]    rd_valid;
  logic [WAYS-1:0]    rd_dirty;
  logic               wr_en = 1'b0;
  logic [INDEX_W-1:0] wr_index = '0;
  logic [WAY_W-1:0]   wr_way = '0;
  logic               wr_valid = 1'b0;
  logic               wr_dirty = 1'b0;
  logic               flush_req = 1'b0;
  logic               busy;
  logic               wb_valid;
  logic [INDEX_W-1:0] wb_index;
  logic [WAY_W-1:0]   wb_way;
  logic               wb_ready = 1'b0;
  logic               done;

  cache_state_array #(.INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (rd_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .wr_en     (wr_en),
    .wr_index  (wr_index),
    .wr_way    (wr_way),
    .wr_valid  (wr_valid),
    .wr_dirty  (wr_dirty),
    .flush_req (flush_req),
    .busy      (busy),
    .wb_valid  (wb_valid),
    .wb_index  (wb_index),
    .wb_way    (wb_way),
    .wb_ready  (wb_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int v; int d; } rd_exp_t;
  typedef struct { int idx; int way; } wb_exp_t;

  rd_exp_t rd_q[$];
  wb_exp_t wb_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int hs_cnt = 0;
  logic rd_issue = 1'b0;
  logic rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= rd_issue;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a read result or writeback is presented.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rd_seen) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got a read result with no expectation queued");
        end else begin
          e = rd_q.pop_front();
          chk($sformatf("rd_valid[set %0d]", e.idx), int'(rd_valid), e.v);
          chk($sformatf("rd_dirty[set %0d]", e.idx), int'(rd_dirty), e.d);
        end
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected: got wb %0d/%0d with nothing expected",
                   wb_index, wb_way);
        end else begin
          chk("wb_index", int'(wb_index), wb_q[0].idx);
          chk("wb_way", int'(wb_way), wb_q[0].way);
          if (wb_ready) begin
            void'(wb_q.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input int idx, input int way, input int v, input int d);
    wr_en    = 1'b1;
    wr_index = INDEX_W'(idx);
    wr_way   = WAY_W'(way);
    wr_valid = v[0];
    wr_dirty = d[0];
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_set(input int idx, input int v, input int d);
    rd_exp_t e;
    e.idx = idx; e.v = v; e.d = d;
    rd_index = INDEX_W'(idx);
    rd_issue = 1'b1;
    rd_q.push_back(e);
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic push_wb(input int idx, input int way);
    wb_exp_t e;
    e.idx = idx; e.way = way;
    wb_q.push_back(e);
  endtask

  task automatic wait_wb(input string name);
    int n = 0;
    while (!wb_valid && n < 100) begin tick(); n++; end
    chk(name, int'(wb_valid), 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin tick(); n++; end
    chk(name, int'(done), 1);
  endtask

  task automatic wb_accept_after_stall(input int idx, input int v, input int d);
    read_set(idx, v, d);
    repeat (4) tick();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("wb_valid_dropped", int'(wb_valid), 0);
    read_set(idx, 0, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) tick();
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_dirty", int'(rd_dirty), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_wb_valid", int'(wb_valid), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b1;
    tick();

    // Reset mid-operation wipes a stored dirty line.
    do_write(3, 1, 1, 1);
    read_set(3, 2, 2);
    tick();
    reset = 1'b0;
    #1;
    chk("async_rst_rd_valid", int'(rd_valid), 0);
    chk("async_rst_rd_dirty", int'(rd_dirty), 0);
    chk("async_rst_busy", int'(busy), 0);
    tick();
    reset = 1'b1;
    for (int s = 0; s < 8; s++) read_set(s, 0, 0);

    // Single-line write and dirty masking.
    do_write(5, 0, 1, 1);
    read_set(5, 1, 1);
    do_write(5, 0, 0, 1);
    read_set(5, 0, 0);

    // Read during write to the same set returns the old value.
    wr_en = 1'b1; wr_index = 3'd2; wr_way = 1'b1; wr_valid = 1'b1; wr_dirty = 1'b0;
    read_set(2, 0, 0);
    wr_en = 1'b0;
    read_set(2, 2, 0);

    // Clean flush of 16 valid lines.
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) do_write(s, w, 1, 0);
    read_set(6, 3, 0);
    busy_cnt = 0; done_cnt = 0; hs_cnt = 0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_done("clean_flush_done");
    tick();
    chk("clean_busy_cycles", busy_cnt, 16);
    chk("clean_done_pulses", done_cnt, 1);
    chk("clean_handshakes", hs_cnt, 0);
    chk("clean_busy_low", int'(busy), 0);
    for (int s = 0; s < 8; s++) read_set(s, 0, 0);

    // Dirty flush with backpressure, ignored flush_req and dropped write while busy.
    do_write(1, 1, 1, 1);
    do_write(6, 0, 1, 1);
    do_write(4, 1, 1, 0);
    push_wb(1, 1);
    push_wb(6, 0);
    done_cnt = 0; hs_cnt = 0;
    flush_req = 1'b1;
    tick();
    tick();
    flush_req = 1'b0;
    tick();
    do_write(0, 1, 1, 1);
    wait_wb("wb_1_1_timeout");
    wb_accept_after_stall(1, 2, 2);
    wait_wb("wb_6_0_timeout");
    wb_accept_after_stall(6, 1, 1);
    wait_done("dirty_flush_done");
    repeat (4) tick();
    chk("no_requeued_flush", int'(busy), 0);
    chk("dirty_done_pulses", done_cnt, 1);
    chk("dirty_handshakes", hs_cnt, 2);
    read_set(0, 0, 0);
    read_set(4, 0, 0);

    // Reset while waiting on a writeback aborts the flush.
    do_write(7, 1, 1, 1);
    push_wb(7, 1);
    done_cnt = 0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_wb("wb_7_1_timeout");
    #2 reset = 1'b0;
    #1;
    chk("abort_wb_valid", int'(wb_valid), 0);
    chk("abort_busy", int'(busy), 0);
    wb_q.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_stays_idle", int'(busy), 0);
    chk("abort_no_wb", int'(wb_valid), 0);
    read_set(7, 0, 0);
    do_write(3, 0, 1, 0);
    read_set(3, 1, 0);
    tick();
    chk("abort_no_done", done_cnt, 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("wb_queue_drained", wb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
